// File: rtl/pulse_ts_pkg.sv
// pulse_ts_pkg
// Shared definitions for the pulse line arbiter: field widths, the output
// word layout, the output register state encoding and the saturating
// drop-counter helper.
package pulse_ts_pkg;

    localparam int TS_WIDTH      = 29;
    localparam int ID_WIDTH      = 3;
    localparam int NUM_LINES_MAX = 8;

    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

    // One output word: {line_id, timestamp}, 32 bits total.
    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [TS_WIDTH-1:0] ts;
    } ts_word_t;

    // Output register occupancy.
    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Add up to eight dropped edges to the counter, clamping at the maximum.
    function automatic logic [15:0] drop_sat_add(input logic [15:0] cnt,
                                                 input logic [3:0]  inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {13'd0, inc};
        if (sum > {1'b0, DROP_CNT_MAX}) begin
            drop_sat_add = DROP_CNT_MAX;
        end else begin
            drop_sat_add = sum[15:0];
        end
    endfunction

endpackage

// File: rtl/pulse_rr_arbiter.sv
// pulse_rr_arbiter
// Purely combinational arbiter choosing one pending line per cycle.
//   req_i        : per-line request (slot occupied)
//   last_grant_i : index of the most recent winner
//   grant_o      : one-hot grant
//   grant_idx_o  : binary index of the granted line
//   grant_vld_o  : at least one request present
// Build option: PULSE_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, last_grant_i ignored); otherwise round-robin starting after
// last_grant_i.
module pulse_rr_arbiter
    import pulse_ts_pkg::*;
#(
    parameter int NUM_LINES = NUM_LINES_MAX
) (
    input  logic [NUM_LINES-1:0] req_i,
    input  logic [ID_WIDTH-1:0]  last_grant_i,
    output logic [NUM_LINES-1:0] grant_o,
    output logic [ID_WIDTH-1:0]  grant_idx_o,
    output logic                 grant_vld_o
);

`ifdef PULSE_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant_i;
`endif

    // Priority search producing the first requesting line in search order.
    always_comb begin
        logic found;
        logic hit;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        hit         = 1'b0;
`ifdef PULSE_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_LINES; i++) begin
            hit         = req_i[i] & ~found;
            grant_o[i]  = hit;
            grant_idx_o = hit ? ID_WIDTH'(i) : grant_idx_o;
            found       = found | hit;
        end
`else
        // First pass covers lines after the last winner, second pass wraps
        // around to line 0 up to and including the last winner.
        for (int i = 0; i < NUM_LINES; i++) begin
            hit         = req_i[i] & ~found & (i > int'(last_grant_i));
            grant_o[i]  = grant_o[i] | hit;
            grant_idx_o = hit ? ID_WIDTH'(i) : grant_idx_o;
            found       = found | hit;
        end
        for (int i = 0; i < NUM_LINES; i++) begin
            hit         = req_i[i] & ~found & (i <= int'(last_grant_i));
            grant_o[i]  = grant_o[i] | hit;
            grant_idx_o = hit ? ID_WIDTH'(i) : grant_idx_o;
            found       = found | hit;
        end
`endif
        grant_vld_o = found;
    end

endmodule

// File: rtl/pulse_line_arbiter.sv
// pulse_line_arbiter
// Captures rising edges on up to NUM_LINES pulse lines, timestamps them with a
// free-running counter and serialises the events as {line_id, ts} words onto
// a valid/ready output feeding the timestamp FIFO.
//   sample_clk : clock
//   resetn     : synchronous active-low reset
//   pulse_i    : pulse lines, synchronous to sample_clk
//   line_en    : per-line enable (disabled edges are neither captured nor dropped)
//   m_tdata    : {line_id[2:0], ts[28:0]}
//   m_tvalid   : output word valid
//   m_tready   : downstream ready
//   pending    : per-line holding slot occupied
//   drop_cnt   : saturating count of edges lost to a full slot
// Build option: PULSE_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
module pulse_line_arbiter
    import pulse_ts_pkg::*;
#(
    parameter int NUM_LINES = NUM_LINES_MAX
) (
    input  logic                 sample_clk,
    input  logic                 resetn,
    input  logic [NUM_LINES-1:0] pulse_i,
    input  logic [NUM_LINES-1:0] line_en,
    output logic [31:0]          m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [NUM_LINES-1:0] pending,
    output logic [15:0]          drop_cnt
);

    logic [TS_WIDTH-1:0]  ts_ctr_q,     ts_ctr_d;
    logic [NUM_LINES-1:0] pulse_q,      pulse_d;
    logic [NUM_LINES-1:0] pending_q,    pending_d;
    logic [TS_WIDTH-1:0]  ts_hold_q [NUM_LINES];
    logic [TS_WIDTH-1:0]  ts_hold_d [NUM_LINES];
    logic [15:0]          drop_cnt_q,   drop_cnt_d;
    logic [ID_WIDTH-1:0]  last_grant_q, last_grant_d;
    out_state_t           state_q,      state_d;
    ts_word_t             tdata_q,      tdata_d;

    logic [NUM_LINES-1:0] grant_s;
    logic [ID_WIDTH-1:0]  grant_idx_s;
    logic                 grant_vld_s;
    logic                 load_s;
    logic [TS_WIDTH-1:0]  sel_ts_s;

    pulse_rr_arbiter #(
        .NUM_LINES (NUM_LINES)
    ) u_arb (
        .req_i        (pending_q),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_s),
        .grant_idx_o  (grant_idx_s),
        .grant_vld_o  (grant_vld_s)
    );

    // A word is loaded whenever something is pending and the output register
    // is empty or being emptied this cycle; this gives back-to-back words.
    always_comb begin
        load_s = grant_vld_s & ((state_q == OUT_EMPTY) | m_tready);
    end

    // Timestamp counter, edge detect, per-line slots and drop counting.
    always_comb begin
        logic [3:0] drop_inc;
        logic       rise;
        logic       granted;
        ts_ctr_d  = ts_ctr_q + 29'd1;
        pulse_d   = pulse_i;
        pending_d = pending_q;
        ts_hold_d = ts_hold_q;
        drop_inc  = 4'd0;
        rise      = 1'b0;
        granted   = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            rise    = pulse_i[i] & ~pulse_q[i] & line_en[i];
            granted = grant_s[i] & load_s;
            // A slot being unloaded this cycle can take a new edge at once.
            if (rise && (!pending_q[i] || granted)) begin
                pending_d[i] = 1'b1;
                ts_hold_d[i] = ts_ctr_q;
            end else if (rise) begin
                drop_inc = drop_inc + 4'd1;
            end else if (granted) begin
                pending_d[i] = 1'b0;
            end else begin
                pending_d[i] = pending_q[i];
            end
        end
        drop_cnt_d = drop_sat_add(drop_cnt_q, drop_inc);
    end

    // Mux the winning line's held timestamp (grant is one-hot).
    always_comb begin
        sel_ts_s = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            sel_ts_s = sel_ts_s | ({TS_WIDTH{grant_s[i]}} & ts_hold_q[i]);
        end
    end

    // Output register next state.
    always_comb begin
        case (state_q)
            OUT_EMPTY: begin
                state_d = load_s ? OUT_FULL : OUT_EMPTY;
            end
            OUT_FULL: begin
                if (load_s) begin
                    state_d = OUT_FULL;
                end else if (m_tready) begin
                    state_d = OUT_EMPTY;
                end else begin
                    state_d = OUT_FULL;
                end
            end
            default: begin
                state_d = OUT_EMPTY;
            end
        endcase
    end

    // Output data and round-robin pointer; both change only on a load.
    always_comb begin
        if (load_s) begin
            tdata_d.id   = grant_idx_s;
            tdata_d.ts   = sel_ts_s;
            last_grant_d = grant_idx_s;
        end else begin
            tdata_d      = tdata_q;
            last_grant_d = last_grant_q;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        m_tvalid = (state_q == OUT_FULL);
        m_tdata  = tdata_q;
        pending  = pending_q;
        drop_cnt = drop_cnt_q;
    end

    // State registers; pulse_q resets high so a line already high at release
    // does not produce an event.
    always_ff @(posedge sample_clk) begin
        if (!resetn) begin
            ts_ctr_q     <= '0;
            pulse_q      <= '1;
            pending_q    <= '0;
            drop_cnt_q   <= 16'h0000;
            last_grant_q <= ID_WIDTH'(NUM_LINES - 1);
            state_q      <= OUT_EMPTY;
            tdata_q      <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                ts_hold_q[i] <= '0;
            end
        end else begin
            ts_ctr_q     <= ts_ctr_d;
            pulse_q      <= pulse_d;
            pending_q    <= pending_d;
            drop_cnt_q   <= drop_cnt_d;
            last_grant_q <= last_grant_d;
            state_q      <= state_d;
            tdata_q      <= tdata_d;
            for (int i = 0; i < NUM_LINES; i++) begin
                ts_hold_q[i] <= ts_hold_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pulse_line_arbiter.sv
// tb_pulse_line_arbiter
// Self-checking bench: a behavioural model predicts every word the arbiter
// should emit and queues it; an independent monitor pops and compares on each
// output handshake. Directed scenarios plus randomized traffic.
module tb_pulse_line_arbiter;
    import pulse_ts_pkg::*;

    localparam int N = 8;

    logic          sample_clk = 1'b0;
    logic          resetn;
    logic [N-1:0]  pulse_i;
    logic [N-1:0]  line_en;
    logic [31:0]   m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic [N-1:0]  pending;
    logic [15:0]   drop_cnt;

    always #5 sample_clk = ~sample_clk;

    pulse_line_arbiter #(.NUM_LINES(N)) dut (
        .sample_clk (sample_clk),
        .resetn     (resetn),
        .pulse_i    (pulse_i),
        .line_en    (line_en),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .pending    (pending),
        .drop_cnt   (drop_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] sb_q [$];

    // Reference model state (state after the most recent clock edge).
    int unsigned mdl_ts;
    bit [N-1:0]  mdl_prev;
    bit [N-1:0]  mdl_pend;
    int unsigned mdl_hold [N];
    int unsigned mdl_drops;
    int          mdl_last;
    bit          mdl_valid;
    logic [31:0] mdl_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void mdl_reset();
        mdl_ts    = 0;
        mdl_prev  = '1;
        mdl_pend  = '0;
        mdl_drops = 0;
        mdl_last  = N - 1;
        mdl_valid = 1'b0;
        mdl_word  = 32'h0000_0000;
        for (int i = 0; i < N; i++) mdl_hold[i] = 0;
    endfunction

    // Predict the effect of the next clock edge given the inputs just driven.
    task automatic mdl_step(input bit [N-1:0] p, input bit [N-1:0] e, input bit tr, input bit rn);
        int winner;
        int j;
        bit [N-1:0] old_pend;
        if (!rn) begin
            // A word handshaken on the reset edge still reaches the FIFO.
            if (!(mdl_valid && tr)) sb_q.delete();
            mdl_reset();
            return;
        end
        winner = -1;
        if (!mdl_valid || tr) begin
`ifdef PULSE_ARB_FIXED_PRIO_EN
            for (int k = 0; k < N; k++)
                if (winner < 0 && mdl_pend[k]) winner = k;
`else
            for (int k = 1; k <= N; k++) begin
                j = (mdl_last + k) % N;
                if (winner < 0 && mdl_pend[j]) winner = j;
            end
`endif
        end
        old_pend = mdl_pend;
        if (winner >= 0) begin
            mdl_word  = (32'(winner) << 29) | 32'(mdl_hold[winner]);
            sb_q.push_back(mdl_word);
            mdl_valid = 1'b1;
            mdl_last  = winner;
            mdl_pend[winner] = 1'b0;
        end else if (tr) begin
            mdl_valid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (p[i] && !mdl_prev[i] && e[i]) begin
                if (old_pend[i] && winner != i) begin
                    if (mdl_drops < 65535) mdl_drops++;
                end else begin
                    mdl_hold[i] = mdl_ts;
                    mdl_pend[i] = 1'b1;
                end
            end
        end
        mdl_prev = p;
        mdl_ts   = (mdl_ts + 1) & 32'h1FFF_FFFF;
    endtask

    // One clock: compare DUT state with the model, then drive the next inputs.
    task automatic cyc(input logic [N-1:0] p, input logic [N-1:0] e,
                       input logic tr, input logic rn, input bit do_force = 1'b0);
        @(posedge sample_clk);
        #2;
        chk("tvalid", 32'(m_tvalid), 32'(mdl_valid));
        if (mdl_valid) chk("tdata", m_tdata, mdl_word);
        chk("pending", 32'(pending), 32'(mdl_pend));
        chk("drop_cnt", 32'(drop_cnt), mdl_drops);
        if (do_force) begin
            force dut.ts_ctr_q = 29'h1FFF_FFFE;
            mdl_ts = 32'h1FFF_FFFE;
            #1;
            release dut.ts_ctr_q;
        end
        pulse_i  = p;
        line_en  = e;
        m_tready = tr;
        resetn   = rn;
        mdl_step(p, e, tr, rn);
    endtask

    // Monitor: pops the scoreboard on every handshake; checks stall stability.
    initial begin
        logic [31:0] last_d;
        bit          stalled;
        stalled = 1'b0;
        last_d  = 32'h0000_0000;
        forever begin
            @(negedge sample_clk);
            if (stalled && m_tvalid) chk("stall_hold", m_tdata, last_d);
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_word: got %08h expected no word at %0t", m_tdata, $time);
                end else begin
                    chk("sb_word", m_tdata, sb_q.pop_front());
                end
            end
            stalled = (m_tvalid === 1'b1) && (m_tready === 1'b0);
            last_d  = m_tdata;
        end
    end

    initial begin
        logic [N-1:0] rp;
        logic [N-1:0] re;
        int exp_id;
        int seen;
        int unsigned ts_a;

        mdl_reset();
        resetn   = 1'b0;
        pulse_i  = '0;
        line_en  = '1;
        m_tready = 1'b0;

        // Reset state
        repeat (3) cyc(8'h00, 8'hFF, 1'b0, 1'b0);
        chk("rst_tvalid", 32'(m_tvalid), 32'h0);
        chk("rst_tdata", m_tdata, 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);

        // Single pulse on line 2 at ts 10
        while (mdl_ts != 10) cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        cyc(8'h04, 8'hFF, 1'b1, 1'b1);
        cyc(8'h04, 8'hFF, 1'b1, 1'b1);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("single_valid", 32'(m_tvalid), 32'h1);
        chk("single_data", m_tdata, 32'h4000_000A);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("single_once", 32'(m_tvalid), 32'h0);

        // Simultaneous edges on lines 0, 3, 7 at ts 20 (fresh pointer)
        cyc(8'h00, 8'hFF, 1'b1, 1'b0);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        while (mdl_ts != 20) cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        cyc(8'h89, 8'hFF, 1'b1, 1'b1);
        cyc(8'h89, 8'hFF, 1'b1, 1'b1);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("simul_w0", m_tdata, 32'h0000_0014);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("simul_w1", m_tdata, 32'h6000_0014);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("simul_w2", m_tdata, 32'hE000_0014);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("simul_end", 32'(m_tvalid), 32'h0);

        // Fairness: lines 1 and 5 toggle every 4 cycles
        exp_id = 1;
        for (int c = 0; c < 64; c++) begin
            cyc((((c / 4) % 2) == 1) ? 8'h22 : 8'h00, 8'hFF, 1'b1, 1'b1);
            if (m_tvalid) begin
                chk("fair_id", 32'(m_tdata[31:29]), 32'(exp_id));
                exp_id = (exp_id == 1) ? 5 : 1;
            end
        end
        chk("fair_drop", 32'(drop_cnt), 32'h0);

        // Backpressure: three edges on line 4 while stalled
        cyc(8'h00, 8'hFF, 1'b0, 1'b0);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1);
        repeat (5) cyc(8'h00, 8'hFF, 1'b0, 1'b1);
        ts_a = mdl_ts;
        cyc(8'h10, 8'hFF, 1'b0, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1);
        cyc(8'h10, 8'hFF, 1'b0, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1);
        cyc(8'h10, 8'hFF, 1'b0, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1);
        chk("bp_drop", 32'(drop_cnt), 32'h1);
        chk("bp_pending", 32'(pending), 32'h10);
        chk("bp_valid", 32'(m_tvalid), 32'h1);
        chk("bp_word1", m_tdata, 32'h8000_0000 | ts_a);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("bp_word2", m_tdata, 32'h8000_0000 | (ts_a + 2));
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("bp_done", 32'(m_tvalid), 32'h0);

        // Timestamp wrap
        cyc(8'h01, 8'hFF, 1'b1, 1'b1, 1'b1);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        cyc(8'h01, 8'hFF, 1'b1, 1'b1);
        chk("wrap_w0", m_tdata, 32'h1FFF_FFFE);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("wrap_valid", 32'(m_tvalid), 32'h1);
        chk("wrap_w1", m_tdata, 32'h0000_0000);

        // Reset mid-operation with a stalled word and four pending lines
        cyc(8'h10, 8'hFF, 1'b0, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1);
        cyc(8'h0F, 8'hFF, 1'b0, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1);
        chk("mid_valid", 32'(m_tvalid), 32'h1);
        chk("mid_pending", 32'(pending), 32'h0F);
        cyc(8'h00, 8'hFF, 1'b0, 1'b0);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("mid_rst_valid", 32'(m_tvalid), 32'h0);
        chk("mid_rst_data", m_tdata, 32'h0);
        chk("mid_rst_pending", 32'(pending), 32'h0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'h0);
        seen = 0;
        repeat (10) begin
            cyc(8'h00, 8'hFF, 1'b1, 1'b1);
            if (m_tvalid) seen++;
        end
        chk("mid_no_words", 32'(seen), 32'h0);

        // Randomized traffic
        rp = '0;
        re = '1;
        for (int c = 0; c < 3000; c++) begin
            rp = rp ^ (N'($urandom) & N'($urandom));
            if ($urandom_range(0, 31) == 0) re = N'($urandom) | N'($urandom);
            cyc(rp, re, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) != 0));
        end

        // Drain everything still expected, bounded
        for (int c = 0; c < 40 && (sb_q.size() != 0 || mdl_valid); c++)
            cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        cyc(8'h00, 8'hFF, 1'b1, 1'b1);
        chk("drain", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
